// File: rtl/truth_table_pkg.sv
`default_nettype none
// ============================================================================
// Package : truth_table_pkg
// Brief   : Shared state encoding and sizing constants for the truth-table
//           sweeper and its hold counter.
// Revision: 1.0 - initial release
// ============================================================================
package truth_table_pkg;

    // A 4-input truth table has 16 rows
    localparam int NUM_VECTORS = 16;
    // Width of the row index driven onto {A,B,C,D}
    localparam int IDX_W       = 4;
    // Error count must reach 16, so it needs one bit more than the index
    localparam int ERR_W       = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } sweep_state_t;

endpackage
`default_nettype wire

// File: rtl/sweep_hold_counter.sv
`default_nettype none
// ============================================================================
// Module  : sweep_hold_counter
// Brief   : Counts the cycles a vector is held; tc flags the last hold cycle
//           (count == HOLD_CYCLES-1) and the counter wraps back to zero there.
// Revision: 1.0 - initial release
// ============================================================================
module sweep_hold_counter #(
    parameter int HOLD_CYCLES = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    // Hold lengths are limited to 1..255, so 8 bits always suffice
    localparam logic [7:0] c_TC_VALUE = 8'(HOLD_CYCLES - 1);

    logic [7:0] r_count;

    // Hold-cycle count: cleared outside a sweep, wraps on terminal count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 8'd0;
        end else if (clear) begin
            r_count <= 8'd0;
        end else if (enable) begin
            if (r_count == c_TC_VALUE) begin
                r_count <= 8'd0;
            end else begin
                r_count <= r_count + 8'd1;
            end
        end
    end

    assign tc = (r_count == c_TC_VALUE);

endmodule
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module  : truth_table_sweeper
// Brief   : Drives all 16 combinations of {A,B,C,D} onto an external circuit,
//           holds each for HOLD_CYCLES, samples E/F at the end of the hold and
//           compares them against the expected truth-table columns.
// Revision: 1.0 - initial release
// ============================================================================
module truth_table_sweeper
    import truth_table_pkg::*;
#(
    parameter int HOLD_CYCLES = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [15:0]       exp_E,
    input  logic [15:0]       exp_F,
    output logic              A,
    output logic              B,
    output logic              C,
    output logic              D,
    input  logic              E,
    input  logic              F,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [IDX_W-1:0]  first_err_idx,
    output logic [15:0]       cap_E,
    output logic [15:0]       cap_F
);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_VECTORS - 1);

    sweep_state_t       r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [15:0]        r_exp_e;
    logic [15:0]        r_exp_f;
    logic [15:0]        r_cap_e;
    logic [15:0]        r_cap_f;
    logic [ERR_W-1:0]   r_err_count;
    logic [IDX_W-1:0]   r_first_err_idx;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;

    logic               w_hold_tc;
    logic               w_hold_clear;
    logic               w_hold_enable;
    logic               w_sample;
    logic               w_mismatch;

    // The hold counter only runs during a sweep and sits at zero otherwise,
    // so the start edge always begins a fresh hold interval
    assign w_hold_clear  = (r_state != SWEEP);
    assign w_hold_enable = (r_state == SWEEP);

    sweep_hold_counter #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (w_hold_clear),
        .enable (w_hold_enable),
        .tc     (w_hold_tc)
    );

    assign w_sample   = (r_state == SWEEP) && w_hold_tc;
    // One mismatch per vector, regardless of how many outputs disagree
    assign w_mismatch = (E != r_exp_e[r_idx]) || (F != r_exp_f[r_idx]);

    // Sweep sequencer, response capture and result bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_idx           <= '0;
            r_exp_e         <= '0;
            r_exp_f         <= '0;
            r_cap_e         <= '0;
            r_cap_f         <= '0;
            r_err_count     <= '0;
            r_first_err_idx <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state         <= SWEEP;
                        r_idx           <= '0;
                        r_busy          <= 1'b1;
                        r_exp_e         <= exp_E;
                        r_exp_f         <= exp_F;
                        r_cap_e         <= '0;
                        r_cap_f         <= '0;
                        r_err_count     <= '0;
                        r_first_err_idx <= '0;
                        r_pass          <= 1'b0;
                    end
                end

                SWEEP: begin
                    if (w_sample) begin
                        r_cap_e[r_idx] <= E;
                        r_cap_f[r_idx] <= F;
                        if (w_mismatch) begin
                            r_err_count <= r_err_count + ERR_W'(1);
                            // Only the first failing row is remembered
                            if (r_err_count == '0) begin
                                r_first_err_idx <= r_idx;
                            end
                        end
                        if (r_idx == c_LAST_IDX) begin
                            // Verdict includes the row sampled on this edge,
                            // so pass is already valid while done is high
                            r_state <= DONE;
                            r_idx   <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (r_err_count == '0) && !w_mismatch;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end

                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end

                default: begin
                    r_state <= IDLE;
                    r_idx   <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign {A, B, C, D}  = r_idx;
    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign err_count     = r_err_count;
    assign first_err_idx = r_first_err_idx;
    assign cap_E         = r_cap_e;
    assign cap_F         = r_cap_f;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module  : tb_truth_table_sweeper
// Brief   : Self-checking bench for truth_table_sweeper. Two sweepers
//           (HOLD_CYCLES 10 and 1) share stimulus and each drive a loopback
//           circuit E=A^B, F=C&D. A timeline model predicts every output from
//           the number of edges since the accepted start.
// Revision: 1.0 - initial release
// ============================================================================
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] exp_E = 16'h0;
    logic [15:0] exp_F = 16'h0;

    logic [1:0]  a_o, b_o, c_o, d_o, e_i, f_i, busy_o, done_o, pass_o;
    logic [4:0]  err_o  [2];
    logic [3:0]  fidx_o [2];
    logic [15:0] cape_o [2];
    logic [15:0] capf_o [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Loopback circuit under test, one per sweeper
    assign e_i = a_o ^ b_o;
    assign f_i = c_o & d_o;

    truth_table_sweeper #(.HOLD_CYCLES(10)) u_h10 (
        .clk(clk), .rst_n(rst_n), .start(start), .exp_E(exp_E), .exp_F(exp_F),
        .A(a_o[0]), .B(b_o[0]), .C(c_o[0]), .D(d_o[0]), .E(e_i[0]), .F(f_i[0]),
        .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
        .err_count(err_o[0]), .first_err_idx(fidx_o[0]),
        .cap_E(cape_o[0]), .cap_F(capf_o[0])
    );

    truth_table_sweeper #(.HOLD_CYCLES(1)) u_h1 (
        .clk(clk), .rst_n(rst_n), .start(start), .exp_E(exp_E), .exp_F(exp_F),
        .A(a_o[1]), .B(b_o[1]), .C(c_o[1]), .D(d_o[1]), .E(e_i[1]), .F(f_i[1]),
        .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
        .err_count(err_o[1]), .first_err_idx(fidx_o[1]),
        .cap_E(cape_o[1]), .cap_F(capf_o[1])
    );

    function automatic int hv(input int i);
        return (i == 0) ? 10 : 1;
    endfunction

    // Reference truth table of the loopback circuit for row k = {A,B,C,D}
    function automatic logic lb_e(input int k);
        return k[3] ^ k[2];
    endfunction

    function automatic logic lb_f(input int k);
        return k[1] & k[0];
    endfunction

    task automatic chk(input string name, input int inst,
                       input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s inst%0d got %0h want %0h", name, inst, got, want);
        end
    endtask

    // Timeline model: per sweeper, whether a sweep is in flight, the edges
    // elapsed since its start edge, the rows sampled so far and the latched
    // expectation columns
    bit          act [2];
    int          el  [2] = '{0, 0};
    int          ns  [2] = '{0, 0};
    logic [15:0] xe  [2];
    logic [15:0] xf  [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                act[i] <= 1'b0;
                el[i]  <= 0;
                ns[i]  <= 0;
                xe[i]  <= 16'h0;
                xf[i]  <= 16'h0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (act[i]) begin
                    el[i] <= el[i] + 1;
                    ns[i] <= ((el[i] + 1) / hv(i) > 16) ? 16 : (el[i] + 1) / hv(i);
                    if (el[i] + 1 > 16 * hv(i)) act[i] <= 1'b0;
                end else if (start) begin
                    act[i] <= 1'b1;
                    el[i]  <= 0;
                    ns[i]  <= 0;
                    xe[i]  <= exp_E;
                    xf[i]  <= exp_F;
                end
            end
        end
    end

    // Compare every output of both sweepers against the model each cycle
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int          h;
            int          ec;
            int          fi;
            logic        bx;
            logic        dx;
            logic        px;
            logic [3:0]  ax;
            logic [15:0] ce;
            logic [15:0] cf;
            h  = hv(i);
            bx = act[i] && (el[i] < 16 * h);
            dx = act[i] && (el[i] == 16 * h);
            ax = bx ? 4'(el[i] / h) : 4'd0;
            ce = 16'h0;
            cf = 16'h0;
            ec = 0;
            fi = -1;
            for (int k = 0; k < 16; k++) begin
                if (k < ns[i]) begin
                    ce[k] = lb_e(k);
                    cf[k] = lb_f(k);
                    if (lb_e(k) != xe[i][k] || lb_f(k) != xf[i][k]) begin
                        ec++;
                        if (fi < 0) fi = k;
                    end
                end
            end
            if (fi < 0) fi = 0;
            px = (ns[i] == 16) && (ec == 0);
            chk("busy", i, 32'(busy_o[i]), 32'(bx));
            chk("done", i, 32'(done_o[i]), 32'(dx));
            chk("abcd", i, 32'({a_o[i], b_o[i], c_o[i], d_o[i]}), 32'(ax));
            chk("cap_E", i, 32'(cape_o[i]), 32'(ce));
            chk("cap_F", i, 32'(capf_o[i]), 32'(cf));
            chk("err_count", i, 32'(err_o[i]), ec);
            chk("first_err_idx", i, 32'(fidx_o[i]), fi);
            chk("pass", i, 32'(pass_o[i]), 32'(px));
        end
    end

    task automatic wait_idle();
        for (int j = 0; j < 500; j++) begin
            @(negedge clk);
            if (busy_o == 2'b00 && done_o == 2'b00) break;
        end
        #1;
    endtask

    // One sweep from idle; returns edges from start edge to the edge where done
    // is sampled high (-1 if it never came)
    task automatic run_sweep(input logic [15:0] e, input logic [15:0] f,
                             output int lat0, output int lat1);
        lat0 = -1;
        lat1 = -1;
        wait_idle();
        exp_E = e;
        exp_F = f;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int j = 0; j < 400; j++) begin
            @(negedge clk);
            if (j < 16) chk("h1_step", 1, 32'({a_o[1], b_o[1], c_o[1], d_o[1]}), j);
            if (done_o[1] && lat1 < 0) lat1 = j + 1;
            if (done_o[0]) begin
                lat0 = j + 1;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int l0;
        int l1;
        int restart;
        int ncyc;
        int rst_at;

        // Reset state
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_ctrl", i, 32'({busy_o[i], done_o[i], pass_o[i], a_o[i], b_o[i],
                                      c_o[i], d_o[i], err_o[i], fidx_o[i]}), 0);
            chk("reset_cap", i, {cape_o[i], capf_o[i]}, 0);
        end
        #1 rst_n = 1'b1;

        // Matching loopback sweep
        run_sweep(16'h0FF0, 16'h8888, l0, l1);
        chk("latency_h10", 0, l0, 161);
        chk("latency_h1", 1, l1, 17);
        chk("good_cap_E", 0, 32'(cape_o[0]), 32'h0FF0);
        chk("good_cap_F", 0, 32'(capf_o[0]), 32'h8888);
        chk("good_pass", 0, 32'(pass_o[0]), 1);
        chk("good_err", 0, 32'(err_o[0]), 0);
        chk("good_pass_h1", 1, 32'(pass_o[1]), 1);

        // Both outputs wrong on row 0 counts once
        run_sweep(16'h0FF1, 16'h8889, l0, l1);
        chk("latency_h10", 0, l0, 161);
        chk("row0_err", 0, 32'(err_o[0]), 1);
        chk("row0_first", 0, 32'(fidx_o[0]), 0);
        chk("row0_pass", 0, 32'(pass_o[0]), 0);

        // Only the last row wrong
        run_sweep(16'h0FF0, 16'h0888, l0, l1);
        chk("row15_err", 0, 32'(err_o[0]), 1);
        chk("row15_first", 0, 32'(fidx_o[0]), 15);
        chk("row15_pass", 0, 32'(pass_o[0]), 0);

        // Reset in the middle of a sweep at row 7
        wait_idle();
        exp_E = 16'h0FF0;
        exp_F = 16'h8888;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int j = 0; j < 200; j++) begin
            @(negedge clk);
            if ({a_o[0], b_o[0], c_o[0], d_o[0]} == 4'd7) break;
        end
        chk("at_row7", 0, 32'({a_o[0], b_o[0], c_o[0], d_o[0]}), 7);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ctrl", 0, 32'({busy_o[0], done_o[0], pass_o[0], a_o[0], b_o[0],
                                  c_o[0], d_o[0], err_o[0], fidx_o[0]}), 0);
        chk("abort_cap", 0, {cape_o[0], capf_o[0]}, 0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        run_sweep(16'h0FF0, 16'h8888, l0, l1);
        chk("after_abort_latency", 0, l0, 161);
        chk("after_abort_pass", 0, 32'(pass_o[0]), 1);

        // Start pulses during a sweep are ignored; a held start relaunches
        wait_idle();
        exp_E = 16'(~16'h0FF0);
        exp_F = 16'h1234;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        restart = -1;
        for (int j = 0; j < 400; j++) begin
            @(negedge clk);
            if (j > 160 && busy_o[0]) begin
                restart = j;
                break;
            end
            #1;
            if (j == 20) start = 1'b1;
            if (j == 21) start = 1'b0;
            if (j == 150) start = 1'b1;
        end
        chk("restart_edge", 0, restart, 162);
        chk("restart_cap_clr", 0, {cape_o[0], capf_o[0]}, 0);
        chk("restart_res_clr", 0, 32'({err_o[0], fidx_o[0], pass_o[0]}), 0);
        #1 start = 1'b0;

        // Randomized traffic: random columns, random start spam, random resets
        for (int it = 0; it < 25; it++) begin
            ncyc   = $urandom_range(30, 220);
            rst_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, ncyc - 1) : -1;
            for (int j = 0; j < ncyc; j++) begin
                @(negedge clk);
                #1;
                start = ($urandom_range(0, 9) == 0);
                if (j == 0 || $urandom_range(0, 19) == 0) begin
                    case ($urandom_range(0, 2))
                        0: begin
                            exp_E = 16'($urandom);
                            exp_F = 16'($urandom);
                        end
                        1: begin
                            exp_E = 16'h0FF0 ^ (16'd1 << $urandom_range(0, 15));
                            exp_F = 16'h8888;
                        end
                        default: begin
                            exp_E = 16'h0FF0;
                            exp_F = 16'h8888;
                        end
                    endcase
                end
                if (j == rst_at) rst_n = 1'b0;
                if (j == rst_at + 2) rst_n = 1'b1;
            end
            rst_n = 1'b1;
            start = 1'b0;
        end
        wait_idle();
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
